pwm_capture_16bits: RTL and testbench

- Input-capture block: measures period and on-time of an incoming gate/PWM signal in `clk` cycles.
- Role: the receiving end of the PWM compare/dead-time outputs. Used for loop-back verification of pwmout_A/B and for external PWM/sync measurement.
- Sits beside the PWM channels and feeds the AXI register bank.
- Reports one measurement per input period, with a valid strobe and a timeout flag.

---
 rtl/PKG_pwm.sv | 28 ++
 rtl/pwm_edge_sync.sv | 81 ++++++++
 rtl/pwm_capture_16bits.sv | 139 +++++++++++++
 tb/tb_pwm_capture_16bits.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/PKG_pwm.sv
// Shared PWM definitions: on/off enable type, capture FSM states, counter width
// and glitch-filter length defaults.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif
`ifndef CAPFILT_LEN
`define CAPFILT_LEN 4
`endif

package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } _cap_state;

  localparam int CAP_CNT_WIDTH   = `PWMCOUNT_WIDTH;
  localparam int CAP_SYNC_STAGES = 2;
  localparam int CAP_FILT_LEN    = `CAPFILT_LEN;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for the capture block: synchronizer, polarity select,
// optional glitch filter (PWMCAP_FILTER_EN) and one-cycle rise/fall pulses.
module pwm_edge_sync
  import PKG_pwm::*;
#(
  parameter int SYNC_STAGES = CAP_SYNC_STAGES
`ifdef PWMCAP_FILTER_EN
  ,
  parameter int FILT_LEN = CAP_FILT_LEN
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  input  logic logic_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_raw;
  logic                   lvl_filt;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign lvl_raw = sync_q[SYNC_STAGES-1] ^ logic_in;

`ifdef PWMCAP_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           filt_q, filt_d;

  // Level flips only after FILT_LEN consecutive samples disagree with it.
  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    if (lvl_raw != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = lvl_raw;
      else                              fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl_filt = filt_q;
`else
  assign lvl_filt = lvl_raw;
`endif

  always_comb begin
    prev_d = lvl_filt;
  end

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = lvl_filt & ~prev_q;
  assign fall = ~lvl_filt & prev_q;

endmodule

// File: rtl/pwm_capture_16bits.sv
// PWM input capture: measures period and on-time of pwm_in in clk cycles.
// Optional glitch filter on the input path is enabled with PWMCAP_FILTER_EN.
module pwm_capture_16bits
  import PKG_pwm::*;
#(
  parameter int CNT_WIDTH   = CAP_CNT_WIDTH,
  parameter int SYNC_STAGES = CAP_SYNC_STAGES
`ifdef PWMCAP_FILTER_EN
  ,
  parameter int FILT_LEN = CAP_FILT_LEN
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  input  logic                 logic_in,
  input  _pwm_onoff            cap_onoff,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] ontime_out,
  output logic                 cap_valid,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic rise, fall;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PWMCAP_FILTER_EN
    ,
    .FILT_LEN(FILT_LEN)
`endif
  ) u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .pwm_in  (pwm_in),
    .logic_in(logic_in),
    .rise    (rise),
    .fall    (fall)
  );

  _cap_state             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  on_lat_q, on_lat_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [CNT_WIDTH-1:0]  ontime_q, ontime_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    on_lat_d  = on_lat_q;
    period_d  = period_q;
    ontime_d  = ontime_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (cap_onoff == PWM_OFF) begin
      state_d  = IDLE;
      cnt_d    = '0;
      on_lat_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_RISE;

        WAIT_RISE: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = HIGH;
          end
        end

        HIGH: begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
              on_lat_d = cnt_q;
              state_d  = LOW;
            end
          end
        end

        LOW: begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_RISE;
          end else if (rise) begin
            period_d  = cnt_q;
            ontime_d  = on_lat_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            state_d   = HIGH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      on_lat_q  <= '0;
      period_q  <= '0;
      ontime_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      on_lat_q  <= on_lat_d;
      period_q  <= period_d;
      ontime_q  <= ontime_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign ontime_out = ontime_q;
  assign cap_valid  = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Self-checking bench for pwm_capture_16bits: directed scenarios plus random
// PWM waveforms checked against an edge-time reference model.
module tb_pwm_capture_16bits;
  import PKG_pwm::*;

`ifdef PWMCAP_FILTER_EN
  localparam int LAT = 3 + 4;
  localparam bit GLITCH_SEEN = 1'b0;
`else
  localparam int LAT = 3;
  localparam bit GLITCH_SEEN = 1'b1;
`endif

  typedef struct {
    int stamp;
    int per;
    int on;
  } meas_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic        logic_in;
  _pwm_onoff   cap_onoff;
  logic [15:0] period_out;
  logic [15:0] ontime_out;
  logic        cap_valid;
  logic        timeout;

  pwm_capture_16bits dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .logic_in  (logic_in),
    .cap_onoff (cap_onoff),
    .period_out(period_out),
    .ontime_out(ontime_out),
    .cap_valid (cap_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: measurement is the spacing of effective-level
  // edges, shifted by a fixed detection latency.
  meas_t exp_q[$];
  meas_t obs_q[$];
  bit    model_en;
  bit    armed;
  bit    fall_seen;
  int    last_rise;
  int    last_fall;
  int    exp_per;
  int    exp_on;
  bit    exp_timeout;

  always @(negedge clk) begin
    if (cap_valid === 1'b1) obs_q.push_back('{cyc, int'(period_out), int'(ontime_out)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic void model_edge(bit eff, int t);
    if (!model_en) return;
    if (eff) begin
      if (armed && fall_seen) begin
        exp_q.push_back('{t + LAT, t - last_rise, last_fall - last_rise});
        exp_per     = t - last_rise;
        exp_on      = last_fall - last_rise;
        exp_timeout = 1'b0;
      end
      armed     = 1'b1;
      fall_seen = 1'b0;
      last_rise = t;
    end else if (armed) begin
      fall_seen = 1'b1;
      last_fall = t;
    end
  endfunction

  task automatic drive(input bit lvl, input int n, input bit seen = 1'b1);
    if (lvl !== pwm_in && seen) model_edge(lvl ^ logic_in, cyc);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit on);
    cap_onoff = on ? PWM_ON : PWM_OFF;
    model_en  = on;
    armed     = 1'b0;
    fall_seen = 1'b0;
  endtask

  task automatic compare(input string name);
    repeat (LAT + 5) @(posedge clk);
    #1;
    check({name, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({name, ".stamp"}, obs_q[i].stamp, exp_q[i].stamp);
      check({name, ".period"}, obs_q[i].per, exp_q[i].per);
      check({name, ".ontime"}, obs_q[i].on, exp_q[i].on);
    end
    check({name, ".period_out"}, period_out, exp_per);
    check({name, ".ontime_out"}, ontime_out, exp_on);
    check({name, ".timeout"}, timeout, exp_timeout);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    pwm_in    = 1'b0;
    logic_in  = 1'b0;
    cap_onoff = PWM_OFF;
    model_en  = 1'b0;
    armed     = 1'b0;
    fall_seen = 1'b0;
    last_rise = 0;
    last_fall = 0;
    exp_per   = 0;
    exp_on    = 0;
    exp_timeout = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.period_out", period_out, 0);
    check("rst.ontime_out", ontime_out, 0);
    check("rst.cap_valid", cap_valid, 0);
    check("rst.timeout", timeout, 0);
    reset = 1'b0;
    set_en(1'b1);
    drive(1'b0, 10);

    // 100/30, active-high
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 30);
      drive(1'b0, 70);
    end
    drive(1'b1, 10);
    compare("p100");
    check("p100.const_period", period_out, 100);
    check("p100.const_ontime", ontime_out, 30);

    // Same waveform, active-low
    drive(1'b0, 10);
    set_en(1'b0);
    logic_in = 1'b1;
    drive(1'b0, 10);
    set_en(1'b1);
    drive(1'b0, 10);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 30);
      drive(1'b0, 70);
    end
    drive(1'b1, 10);
    compare("inv");
    check("inv.const_period", period_out, 100);
    check("inv.const_ontime", ontime_out, 70);

    // Timeout: one rise, then held high
    drive(1'b0, 10);
    set_en(1'b0);
    logic_in = 1'b0;
    drive(1'b0, 10);
    set_en(1'b1);
    drive(1'b0, 10);
    compare("pre_tmo");
    drive(1'b1, 65530);
    check("tmo.before", timeout, 0);
    drive(1'b1, 30);
    check("tmo.after", timeout, 1);
    exp_timeout = 1'b1;
    armed       = 1'b0;
    fall_seen   = 1'b0;
    compare("tmo");
    drive(1'b0, 10);
    drive(1'b1, 20);
    drive(1'b0, 30);
    drive(1'b1, 10);
    compare("p50");
    check("p50.const_period", period_out, 50);
    check("p50.const_ontime", ontime_out, 20);
    check("p50.timeout_clr", timeout, 0);

    // Enable dropped mid-HIGH, restored 10 cycles later
    drive(1'b0, 70);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30);
      drive(1'b0, 70);
    end
    drive(1'b1, 10);
    compare("pre_off");
    set_en(1'b0);
    drive(1'b1, 10);
    check("off.hold_period", period_out, 100);
    check("off.hold_ontime", ontime_out, 30);
    set_en(1'b1);
    drive(1'b1, 10);
    drive(1'b0, 70);
    drive(1'b1, 30);
    drive(1'b0, 70);
    drive(1'b1, 10);
    compare("off");

    // Reset mid-LOW
    drive(1'b1, 20);
    drive(1'b0, 30);
    compare("pre_rst");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst.period_out", period_out, 0);
    check("mid_rst.ontime_out", ontime_out, 0);
    check("mid_rst.cap_valid", cap_valid, 0);
    check("mid_rst.timeout", timeout, 0);
    reset       = 1'b0;
    armed       = 1'b0;
    fall_seen   = 1'b0;
    exp_per     = 0;
    exp_on      = 0;
    exp_timeout = 1'b0;
    drive(1'b0, 20);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 30);
      drive(1'b0, 70);
    end
    drive(1'b1, 10);
    compare("rst");

    // 2-cycle glitch inside a 40/15 waveform
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 15);
      drive(1'b0, 10);
      drive(1'b1, 2, GLITCH_SEEN);
      drive(1'b0, 13, GLITCH_SEEN);
    end
    drive(1'b1, 10);
    compare("glitch");
`ifdef PWMCAP_FILTER_EN
    check("glitch.const_period", period_out, 40);
    check("glitch.const_ontime", ontime_out, 15);
`else
    check("glitch.const_period", period_out, 15);
    check("glitch.const_ontime", ontime_out, 2);
`endif

    // Random waveforms with random polarity
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 10);
      set_en(1'b0);
      logic_in = 1'($urandom_range(0, 1));
      drive(1'b1, 10);
      set_en(1'b1);
      drive(1'b1, 10);
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, $urandom_range(4, 80));
        drive(1'b1, $urandom_range(4, 60));
      end
      drive(1'b0, $urandom_range(4, 80));
      drive(1'b1, 10);
      compare("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
